// File: rtl/ice_cream_pkg.sv
// Shared definitions for the scoop dispenser sequencer: FSM state encodings,
// the ball-count width used by the vending front-ends, and the order clamp.
package ice_cream_pkg;

  localparam int BALL_W  = 2;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ARB   = 3'd1;
  localparam logic [STATE_W-1:0] SCOOP = 3'd2;
  localparam logic [STATE_W-1:0] GAP   = 3'd3;
  localparam logic [STATE_W-1:0] DONE  = 3'd4;
  localparam logic [STATE_W-1:0] TOUT  = 3'd5;

  function automatic logic [BALL_W-1:0] clamp_balls(input logic [BALL_W-1:0] balls,
                                                    input logic [BALL_W-1:0] cap);
    return (balls > cap) ? cap : balls;
  endfunction

endpackage

// File: rtl/ice_cream_dispense_ctrl_if.sv
// Order/dispenser bundle between the vending front-ends, the dispenser and the
// sequencer. The sequencer uses the slave view; the environment drives the master view.
interface ice_cream_dispense_ctrl_if #(
  parameter int N_PORTS = 2
);
  import ice_cream_pkg::*;

  localparam int IDX_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0]        order_valid;
  logic [BALL_W*N_PORTS-1:0] order_balls;
  logic [N_PORTS-1:0]        order_ready;
  logic [N_PORTS-1:0]        served;
  logic                      scoop_req;
  logic [IDX_W-1:0]          scoop_port;
  logic                      scoop_done;
  logic                      busy;
  logic                      fault;
  logic [7:0]                state;

  modport master (
    output order_valid, order_balls, scoop_done,
    input  order_ready, served, scoop_req, scoop_port, busy, fault, state
  );

  modport slave (
    input  order_valid, order_balls, scoop_done,
    output order_ready, served, scoop_req, scoop_port, busy, fault, state
  );

endinterface

// File: rtl/ice_cream_rr_arbiter.sv
// Round-robin pick: first valid port at or after ptr, wrapping. Purely
// combinational; the pointer register is owned by the parent.
module ice_cream_rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [IDX_W-1:0]   ptr,
  input  logic [N_PORTS-1:0] valid,
  output logic [N_PORTS-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    int  j;
    logic found;
    // NOTE: every output gets a default before the search so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      j = (int'(ptr) + i) % N_PORTS;
      if (!found && valid[j]) begin
        found       = 1'b1;
        grant_idx   = IDX_W'(j);
        grant_oh[j] = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/ice_cream_dispense_ctrl.sv
// Sequencer for one shared scoop dispenser behind N vending FSMs: round-robin
// order grant, one scoop per req/done handshake, fixed gap between scoops.
// Optional SCOOP_TIMEOUT_EN adds a scoop watchdog with a sticky fault flag.
module ice_cream_dispense_ctrl
  import ice_cream_pkg::*;
#(
  parameter int N_PORTS   = 2,
  parameter int MAX_BALLS = 2,
  parameter int SCOOP_GAP = 3,
  parameter int TIMEOUT   = 15
) (
  input logic                     clk,
  input logic                     reset,
  ice_cream_dispense_ctrl_if.slave bus
);

  localparam int                 IDX_W    = $clog2(N_PORTS);
  localparam int                 GAP_W    = $clog2(SCOOP_GAP + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PORTS - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(SCOOP_GAP - 1);
  localparam logic [BALL_W-1:0]  BALL_CAP = BALL_W'(MAX_BALLS);

  logic [STATE_W-1:0] state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   grant_q;
  logic [N_PORTS-1:0] grant_oh_q;
  logic [BALL_W-1:0]  remaining_q;
  logic [GAP_W-1:0]   gap_q;

  logic [N_PORTS-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               tmo_hit;

  logic [N_PORTS-1:0][BALL_W-1:0] balls_vec;
  logic [BALL_W-1:0]              clamped;

  assign balls_vec = bus.order_balls;
  assign clamped   = clamp_balls(balls_vec[grant_q], BALL_CAP);

  ice_cream_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .ptr       (ptr_q),
    .valid     (bus.order_valid),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (arb_any) begin
          state_q    <= ARB;
          grant_q    <= arb_idx;
          grant_oh_q <= arb_oh;
        end
        ARB: begin
          remaining_q <= clamped;
          ptr_q       <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          state_q     <= (clamped == '0) ? DONE : SCOOP;
        end
        SCOOP: begin
          if (bus.scoop_done) begin
            remaining_q <= remaining_q - 1'b1;
            gap_q       <= '0;
            state_q     <= (remaining_q == 2'd1) ? DONE : GAP;
          end else if (tmo_hit) begin
            state_q <= TOUT;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= SCOOP;
          else                   gap_q   <= gap_q + 1'b1;
        end
        DONE:    state_q <= IDLE;
        TOUT:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCOOP_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             fault_q;

  // Counter idles at zero outside SCOOP, so each scoop gets a full TIMEOUT window.
  assign tmo_hit = (state_q == SCOOP) && !bus.scoop_done && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == SCOOP) ? tmo_q + 1'b1 : '0;
      if (tmo_hit) fault_q <= 1'b1;
    end
  end

  assign bus.fault = fault_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.fault = 1'b0;
`endif

  assign bus.order_ready = (state_q == ARB)  ? grant_oh_q : '0;
  assign bus.served      = (state_q == DONE) ? grant_oh_q : '0;
  assign bus.scoop_req   = (state_q == SCOOP);
  assign bus.scoop_port  = grant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.state       = {{(8 - STATE_W){1'b0}}, state_q};

endmodule

// File: tb/tb_ice_cream_dispense_ctrl.sv
// Directed bench for ice_cream_dispense_ctrl: dispenser and requester models
// live in tick(); every scenario ends in hand-derived counts and latencies.
module tb_ice_cream_dispense_ctrl;
  import ice_cream_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ice_cream_dispense_ctrl_if #(.N_PORTS(N)) bus();

  ice_cream_dispense_ctrl #(
    .N_PORTS(N), .MAX_BALLS(2), .SCOOP_GAP(3), .TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cycle  = 0;

  int ready_cnt [N];
  int served_cnt[N];
  int rereq     [N];
  int grants[$];
  int grant_last, bursts, req_cycles, req_run, max_run, low_run, last_gap;
  int first_ready, first_req, first_served, port_err, req_age;
  bit dispense_en;
  int done_delay = 2;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      ready_cnt[i] = 0; served_cnt[i] = 0; rereq[i] = 0;
    end
    grants.delete();
    grant_last = -1; bursts = 0; req_cycles = 0; req_run = 0; max_run = 0;
    low_run = 0; last_gap = -1; first_ready = -1; first_req = -1;
    first_served = -1; port_err = 0; req_age = 0; dispense_en = 1'b1;
  endtask

  // One clock: observe outputs 1 time unit after the edge, then update the
  // dispenser and requester models for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < N; i++) begin
      if (bus.order_ready[i]) begin
        ready_cnt[i]++;
        grants.push_back(i);
        grant_last = i;
        if (first_ready < 0) first_ready = cycle;
      end
      if (bus.served[i]) begin
        served_cnt[i]++;
        if (first_served < 0) first_served = cycle;
      end
    end
    if (bus.scoop_req) begin
      if (req_run == 0) begin
        bursts++;
        if (bursts > 1) last_gap = low_run;
        if (first_req < 0) first_req = cycle;
      end
      req_run++;
      req_cycles++;
      if (req_run > max_run) max_run = req_run;
      if (int'(bus.scoop_port) != grant_last) port_err++;
      low_run = 0;
    end else begin
      req_run = 0;
      low_run++;
    end
    if (bus.scoop_req && dispense_en) begin
      req_age++;
      bus.scoop_done = (req_age >= done_delay);
    end else begin
      req_age = 0;
      bus.scoop_done = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.order_ready[i]) begin
        if (rereq[i] > 0) rereq[i]--;
        else              bus.order_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.order_valid = '0;
    bus.order_balls = '0;
    bus.scoop_done  = 1'b0;
    run(2);
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic set_balls(input int p, input int v);
    bus.order_balls[2*p +: 2] = 2'(v);
  endtask

  function automatic int grant_at(input int k);
    return (k < grants.size()) ? grants[k] : -1;
  endfunction

  initial begin
    int t0;
    bit reached;

    // Reset state
    do_reset();
    check("rst_state", int'(bus.state), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_req", int'(bus.scoop_req), 0);
    check("rst_ready", int'(bus.order_ready), 0);
    check("rst_fault", int'(bus.fault), 0);

    // 1: port0, 2 balls
    set_balls(0, 2);
    bus.order_valid = 2'b01;
    t0 = cycle;
    run(20);
    check("t1_ready_lat", first_ready - t0, 1);
    check("t1_req_lat", first_req - t0, 2);
    check("t1_ready_cnt", ready_cnt[0], 1);
    check("t1_bursts", bursts, 2);
    check("t1_gap_low", last_gap, 3);
    check("t1_served", served_cnt[0], 1);
    check("t1_idle", int'(bus.state), 0);

    // 2: both ports from reset, 1 ball each, each re-requests once
    do_reset();
    set_balls(0, 1);
    set_balls(1, 1);
    rereq[0] = 1;
    rereq[1] = 1;
    bus.order_valid = 2'b11;
    run(40);
    check("t2_n_grants", grants.size(), 4);
    check("t2_grant0", grant_at(0), 0);
    check("t2_grant1", grant_at(1), 1);
    check("t2_grant2", grant_at(2), 0);
    check("t2_grant3", grant_at(3), 1);
    check("t2_port_err", port_err, 0);
    check("t2_served", served_cnt[0] + served_cnt[1], 4);

    // 3: zero-ball order on port1
    do_reset();
    set_balls(1, 0);
    bus.order_valid = 2'b10;
    run(10);
    check("t3_ready1", ready_cnt[1], 1);
    check("t3_served1", served_cnt[1], 1);
    check("t3_served_lat", first_served - first_ready, 1);
    check("t3_no_req", req_cycles, 0);
    check("t3_idle", int'(bus.state), 0);

    // 4: 3 balls clamp to 2
    do_reset();
    set_balls(0, 3);
    bus.order_valid = 2'b01;
    run(20);
    check("t4_bursts", bursts, 2);
    check("t4_served", served_cnt[0], 1);
    check("t4_idle", int'(bus.state), 0);

    // 5: dispenser never completes
    do_reset();
    dispense_en = 1'b0;
    set_balls(0, 1);
    bus.order_valid = 2'b01;
`ifdef SCOOP_TIMEOUT_EN
    run(40);
    check("t5_req_cycles", max_run, 15);
    check("t5_req_low", int'(bus.scoop_req), 0);
    check("t5_fault", int'(bus.fault), 1);
    check("t5_no_served", served_cnt[0], 0);
    check("t5_idle", int'(bus.state), 0);
`else
    run(110);
    check("t5_req_held", int'(bus.scoop_req), 1);
    check("t5_hold_ge100", int'(max_run >= 100), 1);
    check("t5_fault", int'(bus.fault), 0);
    check("t5_no_served", served_cnt[0], 0);
`endif

    // 6: reset during GAP, then a fresh contended order starts at port0
    do_reset();
    set_balls(0, 2);
    bus.order_valid = 2'b01;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      tick();
      if (bus.state == 8'd3) reached = 1'b1;
    end
    check("t6_reach_gap", int'(reached), 1);
    reset = 1'b1;
    tick();
    check("t6_state", int'(bus.state), 0);
    check("t6_req", int'(bus.scoop_req), 0);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_port", int'(bus.scoop_port), 0);
    check("t6_no_served", served_cnt[0], 0);
    reset = 1'b0;
    clear_stats();
    set_balls(0, 1);
    set_balls(1, 1);
    bus.order_valid = 2'b11;
    run(3);
    check("t6_first_grant", grant_at(0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
